ring_decoder: RTL and testbench
===============================

# ring_decoder

Receive-side companion to the team's one-hot ring counter. It samples a WIDTH-bit ring vector and converts it to a binary index. It checks that each sample is strictly one-hot and that consecutive samples advance by exactly one position (left rotation, MSB wraps to bit 0). It reports lock status and keeps a saturating error count, and sits at the consumer end of any ring-counter-driven sequencing bus.

## Interface
Parameters:
- WIDTH, 32, ring vector width (>= 2)
- IDX_W, 5, index width; must equal clog2(WIDTH)
- LOCK_COUNT, 4, consecutive correct rotations required to assert locked (>= 1)
- ERR_CNT_W, 16, error counter width

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- ring_in  in  WIDTH  ring vector sample
- ring_vld  in  1  ring_in is meaningful this cycle
- err_clr  in  1  synchronous clear of err_count
- idx  out  IDX_W  bit position of the set bit in the last valid one-hot sample
- idx_vld  out  1  idx updated from this cycle's registered sample
- onehot_err  out  1  one-cycle pulse: sampled vector had zero or more than one bit set
- seq_err  out  1  one-cycle pulse: valid one-hot sample, but not predecessor index + 1 mod WIDTH
- locked  out  1  high while in LOCKED state
- err_count  out  ERR_CNT_W  saturating count of error cycles

## Operation
- Reset values: idx=0, idx_vld=0, onehot_err=0, seq_err=0, locked=0, err_count=0, state=SEARCH, run=0, have_prev=0.
- Classification of each cycle with ring_vld=1:
  - popcount(ring_in)==1 means a good sample.
  - Otherwise (0 or >=2 bits set) it is a one-hot error.
- Good sample:
  - idx is set to the bit position and idx_vld=1.
  - If have_prev=1 and the position != (prev+1) mod WIDTH, seq_err pulses.
  - prev is set to the position and have_prev=1.
- One-hot error:
  - onehot_err pulses, idx_vld=0 and idx holds.
  - have_prev clears.
- ring_vld=0: idx_vld=0, no error pulses, have_prev clears. The sequence check restarts; a gap is not an error.
- onehot_err and seq_err are mutually exclusive by construction.
- State machine (run is a counter 0..LOCK_COUNT):
  - SEARCH: good sample -> TRACK, run=0. Anything else stays in SEARCH.
  - TRACK:
    - Good, in-sequence sample: run+1. If run+1==LOCK_COUNT -> LOCKED.
    - seq_err: stay in TRACK, run=0, new sample becomes the reference.
    - onehot_err or ring_vld=0 -> SEARCH.
  - LOCKED:
    - Good, in-sequence sample: stay.
    - seq_err -> TRACK, run=0.
    - onehot_err or ring_vld=0 -> SEARCH.
- locked = (state==LOCKED), registered.
- err_count:
  - Increments by 1 in each cycle where onehot_err or seq_err is asserted.
  - Saturates at 2^ERR_CNT_W-1 with no wrap.
  - err_clr with no error that cycle sets it to 0.
  - err_clr together with an error sets it to 1.
- Wrap-around: index WIDTH-1 followed by index 0 is in-sequence and is not an error.
- An all-zero vector is an error (onehot_err), never index 0.

## Timing
- All outputs are registered. A sample presented in cycle N produces its idx, idx_vld, onehot_err, seq_err, locked and err_count after the rising edge ending cycle N (1-cycle latency).
- locked rises in the same output cycle as the idx of the LOCK_COUNT-th consecutive in-sequence successor. From the first good sample, this is after LOCK_COUNT+1 good samples.
- locked falls in the same output cycle as the error pulse or idx_vld=0 that broke the sequence.
- err_count reflects an error in the same output cycle as its error pulse.
- Reset asserted mid-operation: the next output cycle shows all reset values, regardless of ring_vld or err_clr. Reset has priority over everything.
- No combinational path from inputs to outputs.

## Test plan
- Lock-up: reset, then a continuous clean rotation 0x00000001, 0x00000002, ... (WIDTH=32, LOCK_COUNT=4) -> idx 0,1,2,3,4 each 1 cycle later; locked rises with idx=4; no error pulses; err_count=0.
- Wrap: locked stream through 0x80000000 then 0x00000001 -> idx 31 then 0, locked stays 1, seq_err=0.
- One-hot violations: inject 0x00000000, then later 0x00000003 -> onehot_err pulses once for each, idx_vld=0 and idx held, locked falls, state SEARCH, err_count=2. Relock requires 5 more good samples.
- Sequence skip while locked: idx 5 followed by 0x00000080 (idx 7) -> seq_err pulse, idx=7, locked falls. The next 4 in-sequence samples (8..11) re-lock with idx=11.
- Gap and counter: drop ring_vld for 1 cycle mid-stream -> idx_vld=0, no error, locked falls. Then:
  - Force 2^ERR_CNT_W+3 errors -> err_count saturates at all-ones.
  - err_clr coincident with an error -> err_count=1.
- Reset mid-lock: assert reset while locked with ring_vld=1 -> next cycle all outputs are at reset values and err_count=0.

Source files
------------

// File: rtl/ring_decoder.sv
// ring_decoder: converts a sampled one-hot ring vector into a binary index,
// checks one-hot validity and single-step left rotation, tracks lock status
// and keeps a saturating count of error cycles. All outputs are registered.
module ring_decoder #(
  parameter int WIDTH      = 32,
  parameter int IDX_W      = 5,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     ring_in,
  input  logic                 ring_vld,
  input  logic                 err_clr,
  output logic [IDX_W-1:0]     idx,
  output logic                 idx_vld,
  output logic                 onehot_err,
  output logic                 seq_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [RUN_W-1:0]     r_run;
  logic [RUN_W-1:0]     w_nextRun;
  logic [RUN_W-1:0]     w_runInc;
  logic                 r_locked;

  logic [IDX_W-1:0]     r_idx;
  logic                 r_idxVld;
  logic                 r_onehotErr;
  logic                 r_seqErr;
  logic                 r_havePrev;
  logic [ERR_CNT_W-1:0] r_errCount;

  logic [IDX_W-1:0]     w_pos;
  logic [IDX_W-1:0]     w_expIdx;
  logic                 w_isOneHot;
  logic                 w_good;
  logic                 w_ohErr;
  logic                 w_seqErr;
  logic                 w_anyErr;

  // A vector is one-hot when it is nonzero and clearing its lowest set bit leaves nothing.
  assign w_isOneHot = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
  assign w_good     = ring_vld & w_isOneHot;
  assign w_ohErr    = ring_vld & ~w_isOneHot;

  // The previous index is always held in r_idx; its successor wraps from WIDTH-1 to 0.
  assign w_expIdx   = (r_idx == IDX_W'(WIDTH - 1)) ? '0 : r_idx + IDX_W'(1);
  assign w_seqErr   = w_good & r_havePrev & (w_pos != w_expIdx);
  assign w_anyErr   = w_ohErr | w_seqErr;
  assign w_runInc   = r_run + RUN_W'(1);

  // Encode the set bit position; only meaningful when the sample is one-hot.
  always_comb begin
    w_pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) begin
        w_pos = IDX_W'(i);
      end
    end
  end

  // Lock FSM next-state: count in-sequence successors until LOCK_COUNT is reached.
  always_comb begin
    w_nextState = r_state;
    w_nextRun   = r_run;
    case (r_state)
      SEARCH: begin
        if (w_good) begin
          w_nextState = TRACK;
          w_nextRun   = '0;
        end
      end
      TRACK: begin
        if (!w_good) begin
          w_nextState = SEARCH;
          w_nextRun   = '0;
        end else if (w_seqErr) begin
          w_nextRun   = '0;
        end else begin
          w_nextRun = w_runInc;
          if (w_runInc == RUN_W'(LOCK_COUNT)) begin
            w_nextState = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (!w_good) begin
          w_nextState = SEARCH;
          w_nextRun   = '0;
        end else if (w_seqErr) begin
          w_nextState = TRACK;
          w_nextRun   = '0;
        end
      end
      default: begin
        w_nextState = SEARCH;
        w_nextRun   = '0;
      end
    endcase
  end

  // Lock FSM state register; locked is registered from the next state so it aligns with idx.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= SEARCH;
      r_run    <= '0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_run    <= w_nextRun;
      r_locked <= (w_nextState == LOCKED);
    end
  end

  // Registered index, validity, error pulses and the saturating error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= '0;
      r_idxVld    <= 1'b0;
      r_onehotErr <= 1'b0;
      r_seqErr    <= 1'b0;
      r_havePrev  <= 1'b0;
      r_errCount  <= '0;
    end else begin
      r_idxVld    <= w_good;
      r_onehotErr <= w_ohErr;
      r_seqErr    <= w_seqErr;
      r_havePrev  <= w_good;
      if (w_good) begin
        r_idx <= w_pos;
      end
      if (err_clr) begin
        r_errCount <= w_anyErr ? ERR_CNT_W'(1) : '0;
      end else if (w_anyErr && (r_errCount != ERR_MAX)) begin
        r_errCount <= r_errCount + ERR_CNT_W'(1);
      end
    end
  end

  assign idx        = r_idx;
  assign idx_vld    = r_idxVld;
  assign onehot_err = r_onehotErr;
  assign seq_err    = r_seqErr;
  assign locked     = r_locked;
  assign err_count  = r_errCount;

endmodule

// File: tb/tb_ring_decoder.sv
// tb_ring_decoder: directed and randomized stimulus for ring_decoder, checked
// cycle by cycle against a chain-and-streak reference model.
module tb_ring_decoder;

  localparam int WIDTH      = 32;
  localparam int IDX_W      = 5;
  localparam int LOCK_COUNT = 4;
  localparam int ERR_CNT_W  = 10;
  localparam int ERR_MAX    = (1 << ERR_CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 tbReset = 1'b1;
  logic [WIDTH-1:0]     ringIn = '0;
  logic                 ringVld = 1'b0;
  logic                 errClr = 1'b0;
  logic [IDX_W-1:0]     idx;
  logic                 idxVld;
  logic                 onehotErr;
  logic                 seqErr;
  logic                 locked;
  logic [ERR_CNT_W-1:0] errCount;

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  // Reference model: a chain of good samples, its in-sequence streak length, and outputs.
  int               mPrev   = -1;
  int               mStreak = 0;
  logic [IDX_W-1:0] mIdx    = '0;
  logic             mIdxVld = 1'b0;
  logic             mOhErr  = 1'b0;
  logic             mSeqErr = 1'b0;
  logic             mLocked = 1'b0;
  int               mErrCnt = 0;

  ring_decoder #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W),
    .LOCK_COUNT(LOCK_COUNT),
    .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk(clk),
    .reset(tbReset),
    .ring_in(ringIn),
    .ring_vld(ringVld),
    .err_clr(errClr),
    .idx(idx),
    .idx_vld(idxVld),
    .onehot_err(onehotErr),
    .seq_err(seqErr),
    .locked(locked),
    .err_count(errCount)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic updateModel(input logic rst, input logic vld, input logic [WIDTH-1:0] vec, input logic clr);
    int p;
    if (rst) begin
      mPrev = -1; mStreak = 0; mIdx = '0; mIdxVld = 0; mOhErr = 0; mSeqErr = 0;
      mLocked = 0; mErrCnt = 0;
    end else begin
      mIdxVld = 0; mOhErr = 0; mSeqErr = 0;
      if (vld && $countones(vec) == 1) begin
        p = $clog2(vec);
        if (mPrev >= 0 && p != (mPrev + 1) % WIDTH) begin
          mSeqErr = 1; mStreak = 0;
        end else if (mPrev >= 0) begin
          mStreak++;
        end else begin
          mStreak = 0;
        end
        mPrev = p; mIdx = IDX_W'(p); mIdxVld = 1;
      end else begin
        if (vld) mOhErr = 1;
        mPrev = -1;
      end
      mLocked = (mPrev >= 0) && (mStreak >= LOCK_COUNT);
      if (clr) mErrCnt = (mOhErr || mSeqErr) ? 1 : 0;
      else if ((mOhErr || mSeqErr) && mErrCnt < ERR_MAX) mErrCnt++;
    end
  endtask

  task automatic checkOutput();
    checks += 6;
    assert (idx === mIdx) else begin
      errors++; $error("FAIL idx: observed %0d expected %0d", idx, mIdx);
    end
    assert (idxVld === mIdxVld) else begin
      errors++; $error("FAIL idx_vld: observed %0b expected %0b", idxVld, mIdxVld);
    end
    assert (onehotErr === mOhErr) else begin
      errors++; $error("FAIL onehot_err: observed %0b expected %0b", onehotErr, mOhErr);
    end
    assert (seqErr === mSeqErr) else begin
      errors++; $error("FAIL seq_err: observed %0b expected %0b", seqErr, mSeqErr);
    end
    assert (locked === mLocked) else begin
      errors++; $error("FAIL locked: observed %0b expected %0b", locked, mLocked);
    end
    assert (errCount === ERR_CNT_W'(mErrCnt)) else begin
      errors++; $error("FAIL err_count: observed %0d expected %0d", errCount, mErrCnt);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic vld, input logic [WIDTH-1:0] vec, input logic clr);
    @(negedge clk);
    tbReset = rst; ringVld = vld; ringIn = vec; errClr = clr;
    @(posedge clk);
    updateModel(rst, vld, vec, clr);
    #1;
    checkOutput();
  endtask

  task automatic sendIdx(input int p);
    logic [WIDTH-1:0] v;
    v = '0;
    v[p] = 1'b1;
    cur = p;
    applyStimulus(1'b0, 1'b1, v, 1'b0);
  endtask

  initial begin
    int r;
    logic [WIDTH-1:0] v;
    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);

    $display("[TB] lock-up and wrap");
    for (int p = 0; p < WIDTH; p++) sendIdx(p);
    for (int p = 0; p < 3; p++) sendIdx(p);

    $display("[TB] one-hot violations");
    applyStimulus(1'b0, 1'b1, 32'h0000_0000, 1'b0);
    for (int p = 3; p < 6; p++) sendIdx(p);
    applyStimulus(1'b0, 1'b1, 32'h0000_0003, 1'b0);
    for (int p = 0; p < 6; p++) sendIdx(p);

    $display("[TB] sequence skip while locked");
    sendIdx(7);
    for (int p = 8; p < 12; p++) sendIdx(p);

    $display("[TB] gap");
    applyStimulus(1'b0, 1'b0, 32'h0000_1000, 1'b0);
    for (int p = 12; p < 15; p++) sendIdx(p);

    $display("[TB] counter saturation and clear");
    for (int n = 0; n < ERR_MAX + 4; n++) applyStimulus(1'b0, 1'b1, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0005, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (($urandom_range(0, 199)) == 0) begin
        applyStimulus(1'b1, 1'b1, $urandom, $urandom_range(0, 1) == 1);
      end else if (r < 60) begin
        sendIdx((cur + 1) % WIDTH);
      end else if (r < 70) begin
        sendIdx($urandom_range(0, WIDTH - 1));
      end else if (r < 78) begin
        v = $urandom;
        applyStimulus(1'b0, 1'b1, v, $urandom_range(0, 19) == 0);
      end else if (r < 85) begin
        v = $urandom;
        applyStimulus(1'b0, 1'b0, v, $urandom_range(0, 19) == 0);
      end else if (r < 88) begin
        applyStimulus(1'b0, 1'b1, '0, $urandom_range(0, 19) == 0);
      end else begin
        sendIdx((cur + 1) % WIDTH);
      end
    end

    $display("[TB] reset mid-lock");
    for (int p = 0; p < 7; p++) sendIdx(p);
    applyStimulus(1'b1, 1'b1, 32'h0000_0080, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
